// File: rtl/fsk_pkg.sv
// Shared definitions for the FSK modulator/demodulator pair: level-tracking
// states and the default signal-chain constants.
package fsk_pkg;

  // Hysteresis level tracker: ACQ until the signal is first seen low.
  typedef enum logic [1:0] {
    ACQ   = 2'd0,
    BELOW = 2'd1,
    ABOVE = 2'd2
  } lvl_state_t;

  localparam int FSK_DW      = 11;    // sample width, offset-binary
  localparam int FSK_CW      = 12;    // period / symbol / vote counter width
  localparam int FSK_MID     = 1024;  // zero-crossing level
  localparam int FSK_HYST    = 64;    // hysteresis half-width
  localparam int FSK_PER_TH  = 96;    // periods below this are the high tone
  localparam int FSK_SYM_LEN = 2048;  // clk cycles per symbol
  localparam int FSK_MAX_PER = 4095;  // period timeout

endpackage

// File: rtl/fsk_zc_demod_if.sv
// Sample-in / recovered-bit-out bundle of the FSK zero-crossing demodulator.
interface fsk_zc_demod_if
  import fsk_pkg::*;
#(
  parameter int DW = FSK_DW,
  parameter int CW = FSK_CW
);
  logic          en;
  logic [DW-1:0] din;
  logic          code_out;
  logic          code_valid;
  logic [CW-1:0] period;
  logic          per_valid;
  logic          carrier_lost;

  // master drives samples and consumes the recovered stream
  modport master (
    output en, din,
    input  code_out, code_valid, period, per_valid, carrier_lost
  );

  // slave is the demodulator itself
  modport slave (
    input  en, din,
    output code_out, code_valid, period, per_valid, carrier_lost
  );
endinterface

// File: rtl/fsk_zc_detect.sv
// Rising zero-crossing detector with hysteresis and carrier period counter.
// Also exports the raw measurement combinationally so the voter can act on
// the same edge that publishes the registered period.
module fsk_zc_detect
  import fsk_pkg::*;
#(
  parameter int DW      = FSK_DW,
  parameter int CW      = FSK_CW,
  parameter int MID     = FSK_MID,
  parameter int HYST    = FSK_HYST,
  parameter int MAX_PER = FSK_MAX_PER
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [CW-1:0] period,
  output logic          per_valid,
  output logic          carrier_lost,
  output logic          meas_stb,
  output logic [CW-1:0] meas_len
);
  localparam logic [DW-1:0] HI_TH   = DW'(MID + HYST);
  localparam logic [DW-1:0] LO_TH   = DW'(MID - HYST);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PER);
  localparam logic [CW-1:0] ONE     = CW'(1);

  lvl_state_t    state_reg, state_next;
  logic [CW-1:0] cnt_reg;
  logic          have_edge_reg;
  logic [CW-1:0] period_reg;
  logic          per_valid_reg;
  logic          lost_reg;
  logic          is_low, is_high, rise;

  assign is_low  = (din < LO_TH);
  assign is_high = (din > HI_TH);

  // level state register, frozen while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  state_reg <= ACQ;
    else if (en) state_reg <= state_next;
  end

  // level transitions; in-band samples never move the state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ACQ:     if (is_low)  state_next = BELOW;
      BELOW:   if (is_high) state_next = ABOVE;
      ABOVE:   if (is_low)  state_next = BELOW;
      default: state_next = ACQ;
    endcase
  end

  // crossing decode: only a genuine period (previous edge, no timeout) is a measurement
  always_comb begin
    rise     = (state_reg == BELOW) && is_high;
    meas_stb = en && rise && have_edge_reg && (cnt_reg < MAX_CNT);
    meas_len = cnt_reg;
  end

  // period counter, carrier supervision and published period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg       <= '0;
      have_edge_reg <= 1'b0;
      period_reg    <= '0;
      per_valid_reg <= 1'b0;
      lost_reg      <= 1'b1;
    end else if (!en) begin
      per_valid_reg <= 1'b0;
    end else begin
      per_valid_reg <= meas_stb;
      if (rise) begin
        // the crossing sample itself is count 1 of the next period
        cnt_reg       <= ONE;
        have_edge_reg <= 1'b1;
        if (meas_stb) begin
          period_reg <= cnt_reg;
          lost_reg   <= 1'b0;
        end else if (cnt_reg == MAX_CNT) begin
          lost_reg <= 1'b1;
        end
      end else if (cnt_reg == MAX_CNT) begin
        // timed out: the next crossing only re-arms the measurement
        lost_reg      <= 1'b1;
        have_edge_reg <= 1'b0;
      end else begin
        cnt_reg <= cnt_reg + ONE;
      end
    end
  end

  assign period       = period_reg;
  assign per_valid    = per_valid_reg;
  assign carrier_lost = lost_reg;

endmodule

// File: rtl/fsk_zc_demod.sv
// FSK zero-crossing demodulator: per-period tone votes are majority-combined
// over a symbol window; a change of tone re-aligns the window to that period.
module fsk_zc_demod
  import fsk_pkg::*;
#(
  parameter int DW      = FSK_DW,
  parameter int CW      = FSK_CW,
  parameter int MID     = FSK_MID,
  parameter int HYST    = FSK_HYST,
  parameter int PER_TH  = FSK_PER_TH,
  parameter int SYM_LEN = FSK_SYM_LEN,
  parameter int MAX_PER = FSK_MAX_PER
) (
  input  logic           clk,
  input  logic           rst_n,
  fsk_zc_demod_if.slave  bus
);
  localparam logic [CW-1:0] TH_CNT   = CW'(PER_TH);
  localparam logic [CW-1:0] LAST_SYM = CW'(SYM_LEN - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic          meas_stb;
  logic [CW-1:0] meas_len;
  logic [CW-1:0] sym_cnt_reg;
  logic [CW-1:0] votes1_reg, votes0_reg;
  logic [CW-1:0] votes1_sum, votes0_sum;
  logic          prev_vote_reg;
  logic          code_out_reg, code_valid_reg;
  logic          vote, resync, boundary;

  fsk_zc_detect #(
    .DW(DW), .CW(CW), .MID(MID), .HYST(HYST), .MAX_PER(MAX_PER)
  ) u_detect (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (bus.en),
    .din          (bus.din),
    .period       (bus.period),
    .per_valid    (bus.per_valid),
    .carrier_lost (bus.carrier_lost),
    .meas_stb     (meas_stb),
    .meas_len     (meas_len)
  );

  // classify the current period and fold it into saturating vote tallies
  always_comb begin
    vote       = (meas_len < TH_CNT);
    resync     = meas_stb && (vote != prev_vote_reg);
    boundary   = bus.en && (sym_cnt_reg == LAST_SYM) && !resync;
    votes1_sum = votes1_reg;
    votes0_sum = votes0_reg;
    if (meas_stb && vote && !(&votes1_reg))   votes1_sum = votes1_reg + ONE;
    if (meas_stb && !vote && !(&votes0_reg))  votes0_sum = votes0_reg + ONE;
  end

  // symbol timing, resync and the per-symbol decision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_cnt_reg    <= '0;
      votes1_reg     <= '0;
      votes0_reg     <= '0;
      prev_vote_reg  <= 1'b0;  // no tone seen yet counts as low tone
      code_out_reg   <= 1'b0;
      code_valid_reg <= 1'b0;
    end else if (!bus.en) begin
      code_valid_reg <= 1'b0;
    end else begin
      code_valid_reg <= boundary;
      if (meas_stb) prev_vote_reg <= vote;
      if (resync) begin
        // tone change marks a symbol start: restart the window with this vote
        sym_cnt_reg <= '0;
        votes1_reg  <= vote ? ONE : '0;
        votes0_reg  <= vote ? '0 : ONE;
      end else if (boundary) begin
        sym_cnt_reg <= '0;
        votes1_reg  <= '0;
        votes0_reg  <= '0;
        if (votes1_sum > votes0_sum)      code_out_reg <= 1'b1;
        else if (votes0_sum > votes1_sum) code_out_reg <= 1'b0;
      end else begin
        sym_cnt_reg <= sym_cnt_reg + ONE;
        votes1_reg  <= votes1_sum;
        votes0_reg  <= votes0_sum;
      end
    end
  end

  assign bus.code_out   = code_out_reg;
  assign bus.code_valid = code_valid_reg;

endmodule

// File: tb/tb_fsk_zc_demod.sv
// Testbench for fsk_zc_demod: table-driven scenarios plus random segments,
// every cycle compared against an event-level reference model.
`timescale 1ns/1ps
module tb_fsk_zc_demod;
  localparam int DW = 11, CW = 12, MID = 1024, HYST = 64, PER_TH = 96;
  localparam int SYM_LEN = 2048, MAX_PER = 4095;
  localparam int HI = MID + HYST, LO = MID - HYST;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fsk_zc_demod_if #(.DW(DW), .CW(CW)) bus ();

  fsk_zc_demod #(
    .DW(DW), .CW(CW), .MID(MID), .HYST(HYST), .PER_TH(PER_TH),
    .SYM_LEN(SYM_LEN), .MAX_PER(MAX_PER)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model: timestamps of crossings and symbol starts in enabled cycles
  int n, last_x, sym_start, v1, v0, m_period;
  bit armed, have, m_lost, m_pv, m_code, m_cv, prev_vote;

  // per-segment observations
  int seg_nvalid, seg_first_per, seg_lat, chg_at;
  bit last_cls = 1'b0;

  typedef struct {
    int rst_cyc; int mode; int half; int ncyc; int gap_at; int gap_len;
    int exp_period; int exp_code; int exp_lost; int exp_nvalid; int exp_first; int exp_lat;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    n = 0; last_x = 0; sym_start = 0; v1 = 0; v0 = 0; m_period = 0;
    armed = 0; have = 0; m_lost = 1; m_pv = 0; m_code = 0; m_cv = 0; prev_vote = 0;
  endtask

  task automatic model_step(input int d);
    bit xing, got, vote;
    int gap, pos;
    m_pv = 0; m_cv = 0; got = 0; vote = 0;
    xing = armed && (d > HI);
    if (d < LO) armed = 1;
    else if (xing) armed = 0;
    gap = n - last_x;
    if (xing) begin
      if (have && gap < MAX_PER) begin
        m_period = gap; m_pv = 1; m_lost = 0; got = 1; vote = (gap < PER_TH);
      end else if (gap >= MAX_PER) m_lost = 1;
      have = 1; last_x = n;
    end else if (gap >= MAX_PER) begin
      m_lost = 1; have = 0;
    end
    pos = n - sym_start;
    if (got && vote != prev_vote) begin
      sym_start = n + 1; v1 = vote ? 1 : 0; v0 = vote ? 0 : 1;
    end else begin
      if (got) begin
        if (vote) v1 = (v1 < 4095) ? v1 + 1 : v1;
        else      v0 = (v0 < 4095) ? v0 + 1 : v0;
      end
      if (pos == SYM_LEN - 1) begin
        m_cv = 1;
        if (v1 > v0) m_code = 1;
        else if (v0 > v1) m_code = 0;
        v1 = 0; v0 = 0; sym_start = n + 1;
      end
    end
    if (got) prev_vote = vote;
    n++;
  endtask

  task automatic compare_all();
    chk("code_out", int'(bus.code_out), int'(m_code));
    chk("code_valid", int'(bus.code_valid), int'(m_cv));
    chk("period", int'(bus.period), m_period);
    chk("per_valid", int'(bus.per_valid), int'(m_pv));
    chk("carrier_lost", int'(bus.carrier_lost), int'(m_lost));
  endtask

  // one clock: drive, step model at the edge, compare 1ns later
  task automatic tick(input int d, input bit e, input int k);
    bit cls;
    bus.din = d[DW-1:0];
    bus.en  = e;
    @(posedge clk);
    if (!rst_n) model_reset();
    else if (e) model_step(d);
    else begin m_pv = 0; m_cv = 0; end
    #1;
    compare_all();
    if (k >= 0) begin
      if (bus.per_valid) begin
        if (seg_first_per < 0) seg_first_per = k;
        cls = (int'(bus.period) < PER_TH);
        if (cls != last_cls) chg_at = k;
        last_cls = cls;
      end
      if (bus.code_valid) begin
        seg_nvalid++;
        if (chg_at >= 0 && seg_lat < 0) seg_lat = k - chg_at;
      end
    end
  endtask

  task automatic do_reset(input int ncyc);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    for (int i = 0; i < ncyc; i++) tick(MID, 1'b1, -1);
    rst_n = 1'b1;
    last_cls = 1'b0;
  endtask

  // mode 0 constant (level=half), 1 tone, 2 tone with in-band noise, 3 random
  task automatic run_seg(input int mode, input int half, input int hi, input int lo,
                         input int ncyc, input int gap_at, input int gap_len, input bit rnd_en);
    int ph, d;
    bit e;
    ph = 0; seg_nvalid = 0; seg_first_per = -1; seg_lat = -1; chg_at = -1;
    for (int k = 0; k < ncyc; k++) begin
      e = 1'b1;
      if (gap_at >= 0 && k >= gap_at && k < gap_at + gap_len) e = 1'b0;
      if (rnd_en && $urandom_range(0, 7) == 0) e = 1'b0;
      if (!e) d = int'($urandom_range(0, 2047));
      else begin
        case (mode)
          0: d = half;
          3: d = int'($urandom_range(0, 2047));
          default: begin
            d = ((ph % (2 * half)) < half) ? hi : lo;
            if (mode == 2 && (ph % 2) == 1) d = (((ph / 2) % 2) == 1) ? 1050 : 1000;
          end
        endcase
        ph++;
      end
      tick(d, e, k);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mode, half, hi, lo, len, gat;
    tbl[0] = '{0, 0, 1024, 5000, -1,   0,   0, 0, 1,  2,  -1,   -1};
    tbl[1] = '{0, 1,   32, 6400, -1,   0,  64, 1, 0,  3, 128, 2048};
    tbl[2] = '{0, 1,   64, 4352, -1,   0, 128, 0, 0,  2,   0, 2048};
    tbl[3] = '{0, 2,   32, 2624, -1,   0,  64, 1, 0,  1,   0, 2048};
    tbl[4] = '{0, 1,   32,  640, 300, 100, 64, 1, 0, -1,   0,   -1};
    tbl[5] = '{0, 0,  500, 4200, -1,   0,  64, 1, 1, -1,  -1,   -1};
    tbl[6] = '{0, 1,   32,  256, -1,   0,  64, 1, 0, -1,  64,   -1};
    tbl[7] = '{0, 1,   32, 1000, -1,   0,  64, 1, 0, -1,  -1,   -1};
    tbl[8] = '{3, 0, 1024, 2100, -1,   0,   0, 0, 1,  1,  -1,   -1};

    bus.en = 1'b0;
    bus.din = 11'd1024;
    #2;
    do_reset(3);

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].rst_cyc > 0) do_reset(tbl[i].rst_cyc);
      run_seg(tbl[i].mode, tbl[i].half, 1500, 500, tbl[i].ncyc,
              tbl[i].gap_at, tbl[i].gap_len, 1'b0);
      $display("row %0d: period=%0d code=%0d lost=%0d nvalid=%0d first_per=%0d lat=%0d",
               i, bus.period, bus.code_out, bus.carrier_lost, seg_nvalid, seg_first_per, seg_lat);
      chk($sformatf("row%0d_period", i), int'(bus.period), tbl[i].exp_period);
      chk($sformatf("row%0d_code", i), int'(bus.code_out), tbl[i].exp_code);
      chk($sformatf("row%0d_lost", i), int'(bus.carrier_lost), tbl[i].exp_lost);
      if (tbl[i].exp_nvalid >= 0) chk($sformatf("row%0d_nvalid", i), seg_nvalid, tbl[i].exp_nvalid);
      if (tbl[i].exp_first >= 0)  chk($sformatf("row%0d_first_per", i), seg_first_per, tbl[i].exp_first);
      if (tbl[i].exp_lat >= 0)    chk($sformatf("row%0d_resync_lat", i), seg_lat, tbl[i].exp_lat);
    end

    // mid-symbol reset during a tone: outputs drop to reset values at once
    run_seg(1, 32, 1500, 500, 700, -1, 0, 1'b0);
    do_reset(3);
    chk("post_reset_period", int'(bus.period), 0);
    chk("post_reset_lost", int'(bus.carrier_lost), 1);

    // random segments against the model
    for (int s = 0; s < 12; s++) begin
      mode = int'($urandom_range(0, 3));
      half = (mode == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(16, 90));
      hi   = int'($urandom_range(1100, 2047));
      lo   = int'($urandom_range(0, 950));
      len  = int'($urandom_range(300, 1500));
      gat  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 200)) : -1;
      run_seg(mode, half, hi, lo, len, gat, int'($urandom_range(1, 120)), s[0]);
      $display("rand %0d: mode=%0d half=%0d len=%0d period=%0d code=%0d lost=%0d",
               s, mode, half, len, bus.period, bus.code_out, bus.carrier_lost);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fsk_zc_demod.md
Name: fsk_zc_demod

Overview:
- Downstream neighbour of the FSK modulator's 11-bit sample output; recovers the transmitted code bit stream.
- Detects rising zero crossings with hysteresis, measures the carrier period in clk cycles, and classifies each period as high-tone or low-tone.
- Majority-votes the period decisions over one symbol window.
- Emits one recovered bit per symbol, with a valid strobe and a carrier-loss flag.

Parameters:
- DW, 11: sample width. Samples are unsigned, offset-binary.
- MID, 1024: sample value at zero crossing (midscale).
- HYST, 64: hysteresis half-width. Thresholds are MID+HYST and MID-HYST.
- PER_TH, 96: periods strictly below PER_TH vote 1 (high tone, code=1); periods greater than or equal to PER_TH vote 0.
- SYM_LEN, 2048: clk cycles per symbol.
- MAX_PER, 4095: period timeout in cycles.
- CW, 12: width of the period counter, symbol counter and vote counters.

Ports:
- clk, in, 1: sample clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- en, in, 1: when low, all counters and state hold and no strobes are issued.
- din, in, DW: modulated sample, one per clk.
- code_out, out, 1: recovered bit.
- code_valid, out, 1: one-cycle strobe; code_out is updated on the same edge.
- period, out, CW: last measured period in cycles.
- per_valid, out, 1: one-cycle strobe when period updates.
- carrier_lost, out, 1: high while no crossing has occurred for MAX_PER cycles.

Behaviour:
- Reset values: code_out=0, code_valid=0, period=0, per_valid=0, carrier_lost=1. Level FSM = ACQ, have_edge=0, all counters 0.
- Level FSM:
  - ACQ → BELOW when din < MID-HYST.
  - BELOW → ABOVE when din > MID+HYST. This transition is a rising crossing.
  - ABOVE → BELOW when din < MID-HYST.
  - Values inside the band never change state.
- Period counter:
  - Increments every enabled cycle and saturates at MAX_PER.
  - On a rising crossing it loads 1.
  - Period = number of clk edges between two successive rising-crossing samples.
- On a rising crossing with have_edge=1 and counter < MAX_PER:
  - period <= counter; per_valid=1 on that same edge (latency 1 from the crossing sample); carrier_lost <= 0.
  - The period's vote is applied.
- The first crossing after reset or after carrier loss only sets have_edge=1. It produces no per_valid and no vote.
- When the counter reaches MAX_PER: carrier_lost <= 1, have_edge <= 0, no votes are added. Symbol timing keeps running.
- Votes:
  - votes1 increments for period < PER_TH; votes0 increments otherwise. Both saturate at 2^CW-1.
- Resync:
  - Triggered when a period's vote differs from the previous period's vote.
  - sym_cnt <= 0; votes cleared, then the current vote is counted.
  - Resync takes precedence over a coincident symbol boundary; no code_valid is issued that cycle.
- Symbol boundary (sym_cnt == SYM_LEN-1, no resync):
  - code_valid=1.
  - code_out <= 1 if votes1 > votes0, 0 if votes0 > votes1, unchanged on a tie (including 0/0).
  - A per_valid vote arriving in the same cycle is included in this decision.
  - After the boundary, votes clear and sym_cnt wraps to 0.
- Otherwise sym_cnt increments on every enabled cycle.
- en low: strobes are 0 and all registers hold. Deasserting en mid-period does not corrupt the counts; counting resumes when en returns high.
- rst_n asserted mid-symbol: immediate return to reset values; no partial bit is emitted.

Decomposition:
- Package fsk_pkg holds the level-state enum (ACQ/BELOW/ABOVE) and the MID/HYST defaults shared with the modulator side.
- One sub-module, fsk_zc_detect: hysteresis FSM plus period counter, outputting period/per_valid/carrier_lost.
- Voting and symbol timing stay in the top.

Test Plan:
- Reset then constant din=1024 for 5000 cycles → carrier_lost stays 1, no per_valid, code_valid every 2048 cycles with code_out=0.
- Square-ish tone of period 64 (din alternating 1500/500, 32 cycles each) for 3 symbols → per_valid every 64 cycles with period=64, code_out=1 at each code_valid.
- Tone of period 128 → period=128, code_out=0. Switching from 64 to 128 mid-symbol → sym_cnt resync; the next code_valid arrives 2048 cycles after the first 128-cycle period is measured, with code_out=0.
- Noise inside the band (din toggling 1000/1050 every cycle) superimposed on a period-64 tone → no extra crossings, period stays 64.
- Period-64 tone, then din held at 500 for 4200 cycles → carrier_lost=1 at MAX_PER; after the tone resumes, the first crossing gives no per_valid and the second gives period=64.
- Assert rst_n low for 3 cycles mid-symbol, and separately hold en low for 100 cycles during a tone → outputs return to reset values; with en low, period is unchanged and the counts are consistent after re-enable.
